ifu_prefetch: RTL

Parametrised successor instruction-fetch unit. It sits between the PC/redirect sources (EXU jump, WB interrupt, IDU ebreak) and the I-cache/IDU. It keeps up to `MAX_OUTSTANDING` cache requests in flight and buffers returned instructions with their PCs in a `FQ_DEPTH` fetch queue, so IDU stalls never lose cache data. Stale responses after a redirect are discarded by a drop counter.

---
 rtl/ifu_prefetch_pkg.sv | 11 +
 rtl/ifu_prefetch_if.sv | 33 +++
 rtl/ifu_prefetch_fetch_fifo.sv | 50 +++++
 rtl/ifu_prefetch.sv | 75 +++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg: shared widths, reset PC and fetch-queue entry type for the prefetch unit
package ifu_prefetch_pkg;
   localparam int RegWidth = 64;
   localparam int INSTWide = 32;
   localparam int MemAddrBus = 32;
   localparam logic [RegWidth-1:0] RESET_PC = 64'h8000_0000;
   typedef struct packed {
      logic [RegWidth-1:0] pc;
      logic [INSTWide-1:0] inst;
   } fq_entry_t;
endpackage

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: redirect, I-cache and IDU signal bundle of the prefetch unit
//   master: prefetch unit view (drives cache_req/addr_inst and the IDU head)
//   slave : environment view (redirect sources, I-cache, IDU)
interface ifu_prefetch_if
   import ifu_prefetch_pkg::*;
#(
   parameter int ADDR_W = RegWidth,
   parameter int INST_W = INSTWide,
   parameter int LINE_W = 2 * INSTWide
);
   logic                  is_jump;
   logic [ADDR_W-1:0]     JumpPc;
   logic                  isIntrPC;
   logic [ADDR_W-1:0]     IntrPC;
   logic                  isebreak;
   logic                  cache_req;
   logic [MemAddrBus-1:0] addr_inst;
   logic                  cache_ready;
   logic                  cache_valid;
   logic [LINE_W-1:0]     inst_i;
   logic                  if_valid;
   logic [INST_W-1:0]     inst_o;
   logic [ADDR_W-1:0]     pc_o;
   logic                  id_allow_in;
   modport master (
      input  is_jump, JumpPc, isIntrPC, IntrPC, isebreak, cache_ready, cache_valid, inst_i, id_allow_in,
      output cache_req, addr_inst, if_valid, inst_o, pc_o
   );
   modport slave (
      output is_jump, JumpPc, isIntrPC, IntrPC, isebreak, cache_ready, cache_valid, inst_i, id_allow_in,
      input  cache_req, addr_inst, if_valid, inst_o, pc_o
   );
endinterface

// File: rtl/ifu_prefetch_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, occupancy count and full/empty flags
//   clk, rst (async active-low), i_flush, i_push/i_data, i_pop/o_data, o_count, o_full, o_empty
//   A push is accepted when full if a pop happens in the same cycle.
module fetch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [W-1:0]               i_data,
   input  logic                       i_pop,
   output logic [W-1:0]               o_data,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_push, w_pop;
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == CW'(DEPTH);
   assign o_count = r_cnt;
   assign o_data  = r_mem[r_rp];
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= w_push ? nxt(r_wp) : r_wp;
         r_rp  <= w_pop ? nxt(r_rp) : r_rp;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction prefetch unit with outstanding-request credits, PC tags and a fetch queue
//   clk, rst (async active-low)
//   bus.master: redirect inputs (is_jump/JumpPc, isIntrPC/IntrPC, isebreak),
//               I-cache request/response (cache_req, addr_inst, cache_ready, cache_valid, inst_i),
//               IDU head (if_valid, inst_o, pc_o, id_allow_in)
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter int                ADDR_W          = RegWidth,
   parameter int                INST_W          = INSTWide,
   parameter int                LINE_W          = 2 * INSTWide,
   parameter int                FQ_DEPTH        = 4,
   parameter int                MAX_OUTSTANDING = 2,
   parameter logic [ADDR_W-1:0] RESET_PC        = ifu_prefetch_pkg::RESET_PC
) (
   input  logic          clk,
   input  logic          rst,
   ifu_prefetch_if.master bus
);
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(FQ_DEPTH + 1);
   localparam int EW  = ADDR_W + INST_W;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [OW-1:0]     r_out, r_drop;
   logic              r_halted;
   logic              w_redirect, w_req_hs, w_keep, w_pop, w_fq_empty, w_fq_full;
   logic              w_tag_full, w_tag_empty, w_unused;
   logic [ADDR_W-1:0] w_target, w_tag;
   logic [INST_W-1:0] w_inst;
   logic [EW-1:0]     w_head;
   logic [FCW-1:0]    w_fq_cnt;
   logic [OW-1:0]     w_tag_cnt;
   logic [31:0]       w_live;
   assign w_redirect = bus.isIntrPC | bus.is_jump;
   assign w_target   = bus.isIntrPC ? bus.IntrPC : bus.JumpPc;
   // Live responses (not marked for dropping) each already own a queue slot.
   assign w_live     = 32'(w_fq_cnt) + 32'(r_out) - 32'(r_drop);
   assign bus.cache_req = rst & ~r_halted & ~w_redirect & (r_out < OW'(MAX_OUTSTANDING)) & (w_live < 32'(FQ_DEPTH));
   assign bus.addr_inst = r_fetch_pc[MemAddrBus-1:0];
   assign w_req_hs   = bus.cache_req & bus.cache_ready;
   assign w_keep     = bus.cache_valid & (r_drop == '0) & ~w_redirect;
   assign w_inst     = w_tag[2] ? bus.inst_i[2*INST_W-1:INST_W] : bus.inst_i[INST_W-1:0];
   assign bus.if_valid = ~w_fq_empty;
   assign w_pop      = bus.if_valid & bus.id_allow_in;
   assign bus.pc_o   = bus.if_valid ? w_head[EW-1:INST_W] : '0;
   assign bus.inst_o = bus.if_valid ? w_head[INST_W-1:0] : '0;
   assign w_unused   = &{w_fq_full, w_tag_full, w_tag_empty, w_tag_cnt, 1'b0};
   fetch_fifo #(.W(EW), .DEPTH(FQ_DEPTH)) u_fq (
      .clk(clk), .rst(rst), .i_flush(w_redirect),
      .i_push(w_keep), .i_data({w_tag, w_inst}),
      .i_pop(w_pop), .o_data(w_head),
      .o_count(w_fq_cnt), .o_full(w_fq_full), .o_empty(w_fq_empty)
   );
   // Tags are never flushed: stale responses still have to consume theirs.
   fetch_fifo #(.W(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_tag (
      .clk(clk), .rst(rst), .i_flush(1'b0),
      .i_push(w_req_hs), .i_data(r_fetch_pc),
      .i_pop(bus.cache_valid), .o_data(w_tag),
      .o_count(w_tag_cnt), .o_full(w_tag_full), .o_empty(w_tag_empty)
   );
   // On redirect every request still in flight after this cycle is stale,
   // including ones already marked by an earlier redirect.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_out      <= '0;
         r_drop     <= '0;
         r_halted   <= 1'b0;
      end else begin
         r_fetch_pc <= w_redirect ? w_target : w_req_hs ? r_fetch_pc + ADDR_W'(4) : r_fetch_pc;
         r_out      <= r_out + OW'(w_req_hs) - OW'(bus.cache_valid);
         r_drop     <= w_redirect ? r_out - OW'(bus.cache_valid) : r_drop - OW'(bus.cache_valid & (r_drop != '0));
         r_halted   <= r_halted | bus.isebreak;
      end
endmodule
